// File: rtl/whack_judge.sv
// Whack-a-mole judge: debounces hole buttons, scores hits against the current
// mole, counts wrong whacks and escaped moles, and ends the game on too many misses.
module whack_judge #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned MAX_MISSES      = 5
) (
    input  logic       clk_out,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mole_pos,
    input  logic [3:0] btn,
    output logic [3:0] mole_led,
    output logic [7:0] score_bcd,
    output logic [3:0] miss_cnt,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       game_over
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] db_cnt [4];
    logic [3:0]       db_level;
    logic [3:0]       db_prev;
    logic [3:0]       press;
    logic [1:0]       mole_cur;
    logic             move;
    logic             hit_c;
    logic             miss_c;
    logic             clear_c;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99) return v;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Per-button debounce: a new level is accepted only after it has differed for DEBOUNCE_CYCLES edges
    always_ff @(posedge clk_out) begin
        if (rst) begin
            db_level <= '0;
            db_prev  <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            db_prev <= db_level;
            for (int i = 0; i < 4; i++) begin
                if (btn[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_level[i] <= btn[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press = db_level & ~db_prev;
    assign move  = (mole_pos != mole_cur);

    always_ff @(posedge clk_out) begin
        if (rst) begin
            mole_cur <= '0;
        end else if (move || (state == IDLE && start)) begin
            mole_cur <= mole_pos;
        end
    end

    always_ff @(posedge clk_out) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A press always wins over a simultaneous move, so that mole never also escapes
    always_comb begin
        state_next = state;
        hit_c      = 1'b0;
        miss_c     = 1'b0;
        clear_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = PLAY;
                    clear_c    = 1'b1;
                end
            end
            PLAY: begin
                if (|press) begin
                    if (press[mole_cur]) begin
                        hit_c      = 1'b1;
                        state_next = HIT;
                    end else begin
                        miss_c = 1'b1;
                    end
                end else if (move) begin
                    miss_c = 1'b1;
                end
            end
            HIT: begin
                if (move) state_next = PLAY;
            end
            OVER: begin
                state_next = OVER;
            end
            default: state_next = IDLE;
        endcase
        if (miss_c && miss_cnt == 4'(MAX_MISSES - 1)) state_next = OVER;
    end

    always_comb begin
        mole_led  = 4'b0000;
        game_over = (state == OVER);
        if (state == PLAY) mole_led = 4'b0001 << mole_cur;
    end

    always_ff @(posedge clk_out) begin
        if (rst) begin
            score_bcd  <= '0;
            miss_cnt   <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            hit_pulse  <= hit_c;
            miss_pulse <= miss_c;
            if (clear_c) begin
                score_bcd <= '0;
                miss_cnt  <= '0;
            end else begin
                if (hit_c)  score_bcd <= bcd_inc(score_bcd);
                if (miss_c) miss_cnt  <= miss_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_whack_judge.sv
// Directed bench for whack_judge: expected judgements are queued when a press
// or move is driven and compared when the DUT emits a hit or miss pulse.
module tb_whack_judge;
    localparam int unsigned DEB  = 4;
    localparam int unsigned MAXM = 3;

    logic       clk_out = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mole_pos;
    logic [3:0] btn;
    logic [3:0] mole_led;
    logic [7:0] score_bcd;
    logic [3:0] miss_cnt;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       game_over;

    whack_judge #(.DEBOUNCE_CYCLES(DEB), .MAX_MISSES(MAXM)) dut (
        .clk_out(clk_out), .rst(rst), .start(start), .mole_pos(mole_pos), .btn(btn),
        .mole_led(mole_led), .score_bcd(score_bcd), .miss_cnt(miss_cnt),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .game_over(game_over)
    );

    always #5 clk_out = ~clk_out;

    typedef struct packed {
        logic       hit;
        logic [7:0] score;
        logic [3:0] miss;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   score_int = 0;
    int   misses    = 0;
    int   lat;

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic push_hit();
        if (score_int < 99) score_int++;
        sb.push_back('{hit: 1'b1, score: to_bcd(score_int), miss: 4'(misses)});
    endtask

    task automatic push_miss();
        misses++;
        sb.push_back('{hit: 1'b0, score: to_bcd(score_int), miss: 4'(misses)});
    endtask

    // Wait (bounded) for the next judgement pulse and compare it with the queued expectation
    task automatic expect_event(input string tag, output int cycles);
        exp_t e;
        bit   seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < 12) begin
            tick();
            cycles++;
            seen = hit_pulse | miss_pulse;
        end
        check({tag, "_seen"}, 32'(hit_pulse | miss_pulse), 32'd1);
        if (seen && sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_hit"},   32'(hit_pulse),  32'(e.hit));
            check({tag, "_miss"},  32'(miss_pulse), 32'(!e.hit));
            check({tag, "_score"}, 32'(score_bcd),  32'(e.score));
            check({tag, "_mcnt"},  32'(miss_cnt),   32'(e.miss));
        end
    endtask

    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check(tag, 32'({hit_pulse, miss_pulse}), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mole_pos = 2'd2; btn = 4'b0000;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_led",   32'(mole_led),  32'd0);
        check("rst_score", 32'(score_bcd), 32'h00);
        check("rst_miss",  32'(miss_cnt),  32'd0);
        check("rst_pulse", 32'({hit_pulse, miss_pulse}), 32'd0);
        check("rst_over",  32'(game_over), 32'd0);

        // Start a game with the mole at hole 2
        start = 1'b1;
        tick();
        start = 1'b0;
        check("play_led",   32'(mole_led),  32'b0100);
        check("play_score", 32'(score_bcd), 32'h00);
        check("play_miss",  32'(miss_cnt),  32'd0);

        // Clean press on the mole's hole: hit DEB+1 edges after the button goes high
        btn = 4'b0100;
        push_hit();
        expect_event("clean_hit", lat);
        check("clean_hit_latency", 32'(lat), 32'(DEB + 1));
        check("hit_led_off", 32'(mole_led), 32'd0);
        btn = 4'b0000;
        quiet("release1", DEB + 2);
        mole_pos = 2'd3;
        tick();
        check("hit_move_nomiss", 32'(miss_pulse), 32'd0);
        check("hit_move_led",    32'(mole_led),   32'b1000);

        // Bouncing wrong button: one miss only
        btn = 4'b0100; tick();
        btn = 4'b0000; tick();
        btn = 4'b0100;
        push_miss();
        expect_event("bounce_miss", lat);
        quiet("bounce_once", DEB + 2);
        btn = 4'b0000;
        quiet("release2", DEB + 2);

        // Press lands in the same cycle the mole moves 3->0: hit on hole 3, no escape
        btn = 4'b1000;
        quiet("pre_press", DEB);
        mole_pos = 2'd0;
        push_hit();
        expect_event("press_move_hit", lat);
        check("press_move_latency", 32'(lat), 32'd1);
        quiet("no_escape", 3);
        btn = 4'b0000;
        quiet("release3", DEB + 2);
        mole_pos = 2'd1;
        tick();
        check("resume_led", 32'(mole_led), 32'b0010);

        // Hit repeatedly up to saturation, then one more at 99
        while (score_int < 99) begin
            btn = 4'b0001 << mole_pos;
            push_hit();
            expect_event("run_hit", lat);
            if (score_int == 10) check("carry_09_10", 32'(score_bcd), 32'h10);
            btn = 4'b0000;
            repeat (DEB + 1) tick();
            mole_pos = mole_pos + 2'd1;
            tick();
        end
        check("score_99", 32'(score_bcd), 32'h99);
        btn = 4'b0001 << mole_pos;
        push_hit();
        expect_event("sat_hit", lat);
        check("sat_score", 32'(score_bcd), 32'h99);
        btn = 4'b0000;
        repeat (DEB + 1) tick();

        // Mid-game reset, then a fresh game driven into OVER
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_score", 32'(score_bcd), 32'h00);
        check("rst2_miss",  32'(miss_cnt),  32'd0);
        check("rst2_led",   32'(mole_led),  32'd0);
        score_int = 0; misses = 0;
        mole_pos = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("play2_led", 32'(mole_led), 32'b0100);

        btn = 4'b0001;
        push_miss();
        expect_event("wrong_btn", lat);
        btn = 4'b0000;
        quiet("release4", DEB + 2);

        btn = 4'b0011;
        push_miss();
        expect_event("multi_btn", lat);
        quiet("multi_once", 2);
        btn = 4'b0000;
        quiet("release5", DEB + 2);
        check("before_over", 32'(game_over), 32'd0);

        mole_pos = 2'd1;
        push_miss();
        expect_event("escape", lat);
        check("escape_latency", 32'(lat), 32'd1);
        check("over_flag", 32'(game_over), 32'd1);
        check("over_mcnt", 32'(miss_cnt),  32'(MAXM));
        check("over_led",  32'(mole_led),  32'd0);

        btn = 4'b0010;
        quiet("over_press", DEB + 4);
        mole_pos = 2'd3;
        quiet("over_move", 2);
        check("over_hold", 32'(miss_cnt), 32'(MAXM));
        btn = 4'b0000;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("final_over",  32'(game_over), 32'd0);
        check("final_led",   32'(mole_led),  32'd0);
        check("final_score", 32'(score_bcd), 32'h00);
        check("final_miss",  32'(miss_cnt),  32'd0);
        check("final_pulse", 32'({hit_pulse, miss_pulse}), 32'd0);
        check("sb_drained",  32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
